// File: rtl/bnn_seq_pkg.sv
// Shared state encoding for the BNN layer sequencer.
// Imported by the sequencer RTL and its testbench.
package bnn_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_LAYER = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_LAYER = ST_LAYER,
        S_DONE  = ST_DONE,
        S_ERR   = ST_ERR
    } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Per-phase watchdog: counts busy cycles since the last clear.
// Instantiated by layer_sequencer only when SEQ_WATCHDOG_EN is defined.
module seq_watchdog #(
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == TIMEOUT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/layer_sequencer.sv
// BNN control sequencer: IDLE -> LOAD -> LAYER[0..N-1] -> DONE.
// Optional per-phase watchdog with sticky ERR state under SEQ_WATCHDOG_EN.
module layer_sequencer
    import bnn_seq_pkg::*;
#(
    parameter int NUM_LAYERS  = 3,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 1000,
    parameter int LIDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  abort,
    input  logic                  err_clr,
    input  logic                  load_done,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [2:0]            state,
    output logic [LIDX_W-1:0]     layer_idx,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic                  busy,
    output logic                  run_done,
    output logic                  err
);

    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NUM_LAYERS - 1);

    seq_state_e            state_q;
    seq_state_e            state_d;
    logic [LIDX_W-1:0]     idx_q;
    logic [LIDX_W-1:0]     idx_d;
    logic [NUM_LAYERS-1:0] start_q;
    logic [NUM_LAYERS-1:0] start_d;
    logic                  timeout;
    logic                  wd_clear;
    logic                  busy_int;

`ifdef SEQ_WATCHDOG_EN
    seq_watchdog #(
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .en      (busy_int),
        .expired (timeout)
    );
`else
    logic unused_wd;
    assign timeout   = 1'b0;
    assign unused_wd = ^{err_clr, wd_clear, TIMEOUT_W[0], TIMEOUT_CYC[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            start_q <= start_d;
        end
    end

    // Priority within each state: abort > done-event > timeout > hold.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        start_d = '0;
        unique case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (!abort && mode) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (load_done) begin
                    state_d    = S_LAYER;
                    idx_d      = '0;
                    start_d[0] = 1'b1;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_LAYER: begin
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (layer_done[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d          = idx_q + 1'b1;
                        start_d[idx_d] = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            S_ERR: begin
`ifdef SEQ_WATCHDOG_EN
                if (abort || err_clr) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
`else
                state_d = S_IDLE;
                idx_d   = '0;
`endif
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign wd_clear = (state_d == S_LOAD && state_q != S_LOAD) || (|start_d);

    always_comb begin
        busy_int = (state_q == S_LOAD) || (state_q == S_LAYER);
        run_done = (state_q == S_DONE);
`ifdef SEQ_WATCHDOG_EN
        err      = (state_q == S_ERR);
`else
        err      = 1'b0;
`endif
    end

    assign busy        = busy_int;
    assign state       = state_q;
    assign layer_idx   = idx_q;
    assign layer_start = start_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed self-checking bench for layer_sequencer (NUM_LAYERS=3).
// Watchdog scenarios run only when SEQ_WATCHDOG_EN is defined.
module tb_layer_sequencer;
    import bnn_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       abort;
    logic       err_clr;
    logic       load_done;
    logic [2:0] layer_done;
    logic [2:0] state;
    logic [1:0] layer_idx;
    logic [2:0] layer_start;
    logic       busy;
    logic       run_done;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    layer_sequencer #(
        .NUM_LAYERS  (3),
        .TIMEOUT_W   (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .abort       (abort),
        .err_clr     (err_clr),
        .load_done   (load_done),
        .layer_done  (layer_done),
        .state       (state),
        .layer_idx   (layer_idx),
        .layer_start (layer_start),
        .busy        (busy),
        .run_done    (run_done),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [2:0] st,
                          input logic [1:0] idx, input logic [2:0] st_pulse);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".idx"}, 32'(layer_idx), 32'(idx));
        chk({tag, ".start"}, 32'(layer_start), 32'(st_pulse));
    endtask

    task automatic clear_in();
        mode       = 1'b0;
        abort      = 1'b0;
        err_clr    = 1'b0;
        load_done  = 1'b0;
        layer_done = 3'b000;
    endtask

    // Drives IDLE -> LOAD -> LAYER idx0 quickly; returns in first LAYER cycle.
    task automatic to_layer0();
        mode = 1'b1;
        step();
        mode      = 1'b0;
        load_done = 1'b1;
        step();
        load_done = 1'b0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk_st("reset", ST_IDLE, 2'd0, 3'b000);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.run_done", 32'(run_done), 32'd0);
        chk("reset.err", 32'(err), 32'd0);

        // abort in IDLE wins over mode
        mode  = 1'b1;
        abort = 1'b1;
        step();
        clear_in();
        chk_st("idle_abort", ST_IDLE, 2'd0, 3'b000);

        // Nominal run with cycle-accurate timing
        mode = 1'b1;
        step();
        mode = 1'b0;
        chk_st("t1", ST_LOAD, 2'd0, 3'b000);
        chk("t1.busy", 32'(busy), 32'd1);
        step();
        chk_st("t2", ST_LOAD, 2'd0, 3'b000);
        step();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk_st("t4", ST_LAYER, 2'd0, 3'b001);
        step();
        chk_st("t5", ST_LAYER, 2'd0, 3'b000);
        layer_done = 3'b001;
        step();
        layer_done = 3'b000;
        chk_st("t6", ST_LAYER, 2'd1, 3'b010);
        step();
        chk_st("t7", ST_LAYER, 2'd1, 3'b000);
        layer_done = 3'b010;
        step();
        layer_done = 3'b000;
        chk_st("t8", ST_LAYER, 2'd2, 3'b100);
        step();
        layer_done = 3'b100;
        step();
        layer_done = 3'b000;
        chk("t10.state", 32'(state), 32'(ST_DONE));
        chk("t10.run_done", 32'(run_done), 32'd1);
        chk("t10.busy", 32'(busy), 32'd0);
        step();
        chk_st("t11", ST_IDLE, 2'd0, 3'b000);
        chk("t11.run_done", 32'(run_done), 32'd0);

        // Wrong layer_done bits are ignored in LAYER idx1
        to_layer0();
        layer_done = 3'b001;
        step();
        chk_st("wrong.enter", ST_LAYER, 2'd1, 3'b010);
        layer_done = 3'b101;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_st("wrong.hold", ST_LAYER, 2'd1, 3'b000);
        end
        layer_done = 3'b010;
        step();
        layer_done = 3'b000;
        chk_st("wrong.next", ST_LAYER, 2'd2, 3'b100);

        // abort beats layer_done in last layer
        abort      = 1'b1;
        layer_done = 3'b100;
        step();
        clear_in();
        chk_st("abort", ST_IDLE, 2'd0, 3'b000);
        chk("abort.run_done", 32'(run_done), 32'd0);
        step();
        chk("abort.run_done2", 32'(run_done), 32'd0);

        // Synchronous reset mid-LAYER, mode held high
        to_layer0();
        layer_done = 3'b001;
        step();
        layer_done = 3'b000;
        mode = 1'b1;
        rst  = 1'b1;
        step();
        chk_st("rst", ST_IDLE, 2'd0, 3'b000);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.run_done", 32'(run_done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        rst = 1'b0;
        step();
        chk_st("rst.rel", ST_LOAD, 2'd0, 3'b000);
        clear_in();
        abort = 1'b1;
        step();
        clear_in();
        chk_st("rst.abort", ST_IDLE, 2'd0, 3'b000);

`ifdef SEQ_WATCHDOG_EN
        // LOAD stalls: ERR 8 cycles after LOAD entry
        mode = 1'b1;
        step();
        mode = 1'b0;
        chk_st("wd.load", ST_LOAD, 2'd0, 3'b000);
        for (int i = 0; i < 7; i++) step();
        chk("wd.t8", 32'(state), 32'(ST_LOAD));
        step();
        chk("wd.t9", 32'(state), 32'(ST_ERR));
        chk("wd.err", 32'(err), 32'd1);
        chk("wd.busy", 32'(busy), 32'd0);
        mode = 1'b1;
        step();
        step();
        chk("wd.sticky", 32'(state), 32'(ST_ERR));
        mode    = 1'b0;
        err_clr = 1'b1;
        step();
        clear_in();
        chk_st("wd.clr", ST_IDLE, 2'd0, 3'b000);
        chk("wd.clr.err", 32'(err), 32'd0);

        // load_done on the expiring cycle wins; counter restarts in LAYER
        mode = 1'b1;
        step();
        mode = 1'b0;
        for (int i = 0; i < 7; i++) step();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        chk_st("wd.race", ST_LAYER, 2'd0, 3'b001);
        chk("wd.race.err", 32'(err), 32'd0);
        for (int i = 0; i < 7; i++) step();
        chk("wd.lay.t7", 32'(state), 32'(ST_LAYER));
        step();
        chk("wd.lay.t8", 32'(state), 32'(ST_ERR));
        abort = 1'b1;
        step();
        clear_in();
        chk_st("wd.abort", ST_IDLE, 2'd0, 3'b000);
`else
        // Without the watchdog a stalled LOAD never errors
        mode = 1'b1;
        step();
        mode = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("nowd.state", 32'(state), 32'(ST_LOAD));
        chk("nowd.err", 32'(err), 32'd0);
        err_clr = 1'b1;
        step();
        chk("nowd.errclr", 32'(state), 32'(ST_LOAD));
        clear_in();
        abort = 1'b1;
        step();
        clear_in();
        chk_st("nowd.abort", ST_IDLE, 2'd0, 3'b000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
